pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_reg_pkg.sv | 27 ++
 rtl/pipe_stage_slot.sv | 52 +++++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// ============================================================================
// Module      : pipe_reg_pkg
// Description : Shared widths, occupancy type and occupancy helper for the
//               pipeline stage register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pipe_reg_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CTRL_WIDTH = 8;

  typedef logic [1:0] occ_t;

  // Entry count after an edge; flush wins over any push or pop.
  function automatic occ_t occ_next(input occ_t occ, input logic push,
                                    input logic pop, input logic flush);
    occ_t r;
    if (flush) r = '0;
    else       r = occ + occ_t'(push) - occ_t'(pop);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_slot.sv
// ============================================================================
// Module      : pipe_stage_slot
// Description : One valid/data/ctrl holding register with async reset and a
//               synchronous clear. Priority: clear, load, drop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic                  i_drop,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CTRL_WIDTH-1:0] r_ctrl;

  // Data/ctrl are only written on load, so a cleared slot keeps its last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with flush. Define
//               PIPE_STAGE_SKID_EN for a 2-deep skid version with registered
//               IN_READY; otherwise depth 1 with combinational IN_READY.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  output occ_t                  OCCUPANCY
);

  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop = w_head_valid && OUT_READY;

`ifdef PIPE_STAGE_SKID_EN
  logic                  r_in_ready;
  logic                  w_skid_valid;
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic [CTRL_WIDTH-1:0] w_skid_ctrl;
  logic                  w_main_load;
  logic                  w_main_drop;
  logic                  w_skid_load;
  logic                  w_skid_drop;
  occ_t                  w_occ;
  occ_t                  w_occ_next;

  assign IN_READY   = r_in_ready;
  assign w_push     = IN_VALID && r_in_ready;
  assign w_occ      = occ_t'(w_head_valid) + occ_t'(w_skid_valid);
  assign w_occ_next = occ_next(w_occ, w_push, w_pop, FLUSH);

  // Head refills from the skid slot first so order is preserved.
  assign w_main_load = (!w_head_valid || w_pop) && (w_skid_valid || w_push);
  assign w_main_drop = w_pop && !w_skid_valid && !w_push;
  assign w_skid_load = w_push && w_head_valid && !w_pop;
  assign w_skid_drop = w_pop && w_skid_valid;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_occ_next != 2'd2);
  end

  pipe_stage_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
    .clk     (CLK),
    .rst     (RESET),
    .i_clr   (FLUSH),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_skid_valid ? w_skid_data : IN_DATA),
    .i_ctrl  (w_skid_valid ? w_skid_ctrl : IN_CTRL),
    .o_valid (w_head_valid),
    .o_data  (w_head_data),
    .o_ctrl  (w_head_ctrl)
  );

  pipe_stage_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
    .clk     (CLK),
    .rst     (RESET),
    .i_clr   (FLUSH),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_data  (IN_DATA),
    .i_ctrl  (IN_CTRL),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl)
  );

  assign OCCUPANCY = w_occ;
`else
  assign IN_READY = !w_head_valid || OUT_READY;
  assign w_push   = IN_VALID && IN_READY;

  pipe_stage_slot #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
    .clk     (CLK),
    .rst     (RESET),
    .i_clr   (FLUSH),
    .i_load  (w_push),
    .i_drop  (w_pop && !w_push),
    .i_data  (IN_DATA),
    .i_ctrl  (IN_CTRL),
    .o_valid (w_head_valid),
    .o_data  (w_head_data),
    .o_ctrl  (w_head_ctrl)
  );

  assign OCCUPANCY = {1'b0, w_head_valid};
`endif

  assign OUT_VALID = w_head_valid;
  assign OUT_DATA  = w_head_data;
  assign OUT_CTRL  = w_head_valid ? w_head_ctrl : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg; exercises the
//               skid build when PIPE_STAGE_SKID_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic [7:0]  IN_CTRL;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [7:0]  OUT_CTRL;
  logic [1:0]  OCCUPANCY;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_CTRL   (IN_CTRL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CTRL  (OUT_CTRL),
    .OCCUPANCY (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [7:0] c, input logic [1:0] occ);
    chk({tag, ".valid"}, {31'd0, OUT_VALID}, {31'd0, v});
    chk({tag, ".data"},  OUT_DATA, d);
    chk({tag, ".ctrl"},  {24'd0, OUT_CTRL}, {24'd0, c});
    chk({tag, ".occ"},   {30'd0, OCCUPANCY}, {30'd0, occ});
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100;
    IN_CTRL = 8'h11; OUT_READY = 1'b1;

    // Reset with a push offered
    #2;
    chk_out("rst_async", 1'b0, 32'd0, 8'h00, 2'd0);
    chk("rst_inready", {31'd0, IN_READY}, 32'd1);
    tick(); tick();
    chk_out("rst_edges", 1'b0, 32'd0, 8'h00, 2'd0);
    RESET = 1'b0; IN_VALID = 1'b0;
    tick();
    chk_out("rst_release", 1'b0, 32'd0, 8'h00, 2'd0);

    // Stream with OUT_READY=1
    IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h01;
    tick(); chk_out("stream100", 1'b1, 32'd100, 8'h01, 2'd1);
    IN_DATA = 32'd300; IN_CTRL = 8'h02;
    tick(); chk_out("stream300", 1'b1, 32'd300, 8'h02, 2'd1);
    IN_DATA = 32'd500; IN_CTRL = 8'h04;
    tick(); chk_out("stream500", 1'b1, 32'd500, 8'h04, 2'd1);
    IN_VALID = 1'b0;
    tick(); chk_out("stream_end", 1'b0, 32'd500, 8'h00, 2'd0);

    // Bubble: control zeroed, data held
    IN_VALID = 1'b1; IN_DATA = 32'h2A; IN_CTRL = 8'hFF;
    tick(); chk_out("bubble_push", 1'b1, 32'h2A, 8'hFF, 2'd1);
    IN_VALID = 1'b0;
    tick(); chk_out("bubble_pop", 1'b0, 32'h2A, 8'h00, 2'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid slot
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h03;
    tick(); chk_out("bp_one", 1'b1, 32'd100, 8'h03, 2'd1);
    chk("bp_one_rdy", {31'd0, IN_READY}, 32'd1);
    IN_DATA = 32'd300; IN_CTRL = 8'h05;
    tick(); chk_out("bp_two", 1'b1, 32'd100, 8'h03, 2'd2);
    chk("bp_two_rdy", {31'd0, IN_READY}, 32'd0);
    IN_DATA = 32'd999;
    tick(); chk_out("bp_hold", 1'b1, 32'd100, 8'h03, 2'd2);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick(); chk_out("bp_pop1", 1'b1, 32'd300, 8'h05, 2'd1);
    chk("bp_pop1_rdy", {31'd0, IN_READY}, 32'd1);
    tick(); chk_out("bp_pop2", 1'b0, 32'd300, 8'h00, 2'd0);

    // Fill to two for the flush
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h03;
    tick(); IN_DATA = 32'd300;
    tick(); chk("fl_fill", {30'd0, OCCUPANCY}, 32'd2);
`else
    // Depth-1: combinational IN_READY
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h03;
    tick(); chk_out("ns_hold", 1'b1, 32'd100, 8'h03, 2'd1);
    IN_DATA = 32'd300; IN_CTRL = 8'h05;
    #1; chk("ns_rdy0", {31'd0, IN_READY}, 32'd0);
    tick(); chk_out("ns_stall", 1'b1, 32'd100, 8'h03, 2'd1);
    OUT_READY = 1'b1;
    #1; chk("ns_rdy1", {31'd0, IN_READY}, 32'd1);
    tick(); chk_out("ns_advance", 1'b1, 32'd300, 8'h05, 2'd1);
    IN_VALID = 1'b0;
    tick(); chk_out("ns_drain", 1'b0, 32'd300, 8'h00, 2'd0);

    // Fill to one for the flush
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h03;
    tick(); chk("fl_fill", {30'd0, OCCUPANCY}, 32'd1);
`endif

    // Flush beats the concurrent push and pop
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'd700; IN_CTRL = 8'h07; OUT_READY = 1'b1;
    tick(); chk("flush_occ", {30'd0, OCCUPANCY}, 32'd0);
    chk("flush_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("flush_ctrl", {24'd0, OUT_CTRL}, 32'd0);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    tick(); chk("flush_no700", {31'd0, OUT_VALID}, 32'd0);
    chk("flush_in_ready", {31'd0, IN_READY}, 32'd1);

    // Reset in the middle of a transfer
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd100; IN_CTRL = 8'h09;
    tick(); chk_out("mid_held", 1'b1, 32'd100, 8'h09, 2'd1);
    #1; RESET = 1'b1;
    #1; chk_out("mid_rst", 1'b0, 32'd0, 8'h00, 2'd0);
    chk("mid_rst_rdy", {31'd0, IN_READY}, 32'd1);
    tick(); chk_out("mid_rst_edge", 1'b0, 32'd0, 8'h00, 2'd0);
    RESET = 1'b0; IN_DATA = 32'd300; IN_CTRL = 8'h0A;
    tick(); chk_out("mid_first_push", 1'b1, 32'd300, 8'h0A, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
